decode_stage: RTL and testbench

Registered, multi-lane instruction decode stage sitting between the fetch queue and rename. Each cycle it accepts a bundle of up to DECODE_NUM 32-bit RV64I instructions and decodes register fields, immediates and operand-valid flags. It also adds three things a plain decoder lacks: illegal-opcode detection, x0-aware valid flags, and truncation of the bundle after the first illegal lane. Output is held in a single pipeline register with valid/ready backpressure and a flush input.

---
 rtl/decode_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Multi-lane RV64I decode stage: field extraction, immediates, x0-aware operand flags,
// illegal-lane detection with bundle truncation, one registered output slot with backpressure.
module decode_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int DECODE_NUM = 4,
  parameter int PC_WIDTH   = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [32*DECODE_NUM-1:0]         in_instr,
  input  logic [DECODE_NUM-1:0]            in_lane_v,
  input  logic [PC_WIDTH-1:0]              in_pc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DECODE_NUM-1:0]            out_lane_v,
  output logic [PC_WIDTH*DECODE_NUM-1:0]   out_pc,
  output logic [7*DECODE_NUM-1:0]          out_opcode,
  output logic [3*DECODE_NUM-1:0]          out_func3,
  output logic [DECODE_NUM-1:0]            out_func7,
  output logic [5*DECODE_NUM-1:0]          out_rs1,
  output logic [5*DECODE_NUM-1:0]          out_rs2,
  output logic [5*DECODE_NUM-1:0]          out_rd,
  output logic [DATA_WIDTH*DECODE_NUM-1:0] out_imme,
  output logic [DECODE_NUM-1:0]            out_prs1_v,
  output logic [DECODE_NUM-1:0]            out_prs2_v,
  output logic [DECODE_NUM-1:0]            out_prd_v,
  output logic [DECODE_NUM-1:0]            out_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IW    = 7'b0011011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
    logic [DATA_WIDTH-1:0] r;
    r       = {DATA_WIDTH{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  logic [DECODE_NUM-1:0] w_cls_r, w_cls_i, w_cls_u, w_cls_j, w_cls_b, w_cls_s;
  logic [DECODE_NUM-1:0] w_bad, w_lane_v, w_illegal;
  logic [DECODE_NUM-1:0] w_prs1_v, w_prs2_v, w_prd_v, w_func7;
  logic [PC_WIDTH*DECODE_NUM-1:0]   w_pc;
  logic [7*DECODE_NUM-1:0]          w_opcode;
  logic [3*DECODE_NUM-1:0]          w_func3;
  logic [5*DECODE_NUM-1:0]          w_rs1, w_rs2, w_rd;
  logic [DATA_WIDTH*DECODE_NUM-1:0] w_imme;
  logic                             w_xfer;

  logic                             r_valid;
  logic [DECODE_NUM-1:0]            r_lane_v, r_illegal, r_prs1_v, r_prs2_v, r_prd_v, r_func7;
  logic [PC_WIDTH*DECODE_NUM-1:0]   r_pc;
  logic [7*DECODE_NUM-1:0]          r_opcode;
  logic [3*DECODE_NUM-1:0]          r_func3;
  logic [5*DECODE_NUM-1:0]          r_rs1, r_rs2, r_rd;
  logic [DATA_WIDTH*DECODE_NUM-1:0] r_imme;

  always_comb begin : classify
    w_cls_r = '0;
    w_cls_i = '0;
    w_cls_u = '0;
    w_cls_j = '0;
    w_cls_b = '0;
    w_cls_s = '0;
    w_bad   = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      case (in_instr[32*i +: 7])
        OP_R, OP_RW:                    w_cls_r[i] = 1'b1;
        OP_JALR, OP_LOAD, OP_I, OP_IW:  w_cls_i[i] = 1'b1;
        OP_LUI, OP_AUIPC:               w_cls_u[i] = 1'b1;
        OP_JAL:                         w_cls_j[i] = 1'b1;
        OP_B:                           w_cls_b[i] = 1'b1;
        OP_STORE:                       w_cls_s[i] = 1'b1;
        default:                        ;
      endcase
      w_bad[i] = in_lane_v[i] &
                 (~(w_cls_r[i] | w_cls_i[i] | w_cls_u[i] | w_cls_j[i] | w_cls_b[i] | w_cls_s[i]) |
                  (in_instr[32*i +: 2] != 2'b11));
    end
  end

  // Lanes up to and including the first illegal one survive; everything younger is dropped.
  always_comb begin : truncate
    logic seen;
    seen      = 1'b0;
    w_lane_v  = '0;
    w_illegal = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      if (!seen) begin
        w_lane_v[i] = in_lane_v[i];
        if (w_bad[i]) begin
          w_illegal[i] = 1'b1;
          seen         = 1'b1;
        end
      end
    end
  end

  always_comb begin : decode
    logic [31:0] ins;
    logic        ok;
    ins      = '0;
    ok       = 1'b0;
    w_pc     = '0;
    w_opcode = '0;
    w_func3  = '0;
    w_func7  = '0;
    w_rs1    = '0;
    w_rs2    = '0;
    w_rd     = '0;
    w_imme   = '0;
    w_prs1_v = '0;
    w_prs2_v = '0;
    w_prd_v  = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      ins = in_instr[32*i +: 32];
      ok  = w_lane_v[i] & ~w_illegal[i];
      w_pc[PC_WIDTH*i +: PC_WIDTH] = in_pc + (PC_WIDTH'(i) << 2);
      w_opcode[7*i +: 7] = ins[6:0];
      w_func3[3*i +: 3]  = ins[14:12];
      w_func7[i]         = ins[30];
      w_rs1[5*i +: 5]    = ins[19:15];
      w_rs2[5*i +: 5]    = ins[24:20];
      w_rd[5*i +: 5]     = ins[11:7];
      // Reads/writes of x0 never create a dependency, so those flags stay low.
      w_prs1_v[i] = ok & (w_cls_r[i] | w_cls_i[i] | w_cls_s[i] | w_cls_b[i]) & (|ins[19:15]);
      w_prs2_v[i] = ok & (w_cls_r[i] | w_cls_s[i] | w_cls_b[i]) & (|ins[24:20]);
      w_prd_v[i]  = ok & (w_cls_r[i] | w_cls_i[i] | w_cls_u[i] | w_cls_j[i]) & (|ins[11:7]);
      if (w_illegal[i])    w_imme[DATA_WIDTH*i +: DATA_WIDTH] = '0;
      else if (w_cls_i[i]) w_imme[DATA_WIDTH*i +: DATA_WIDTH] = sext32(imm_i(ins));
      else if (w_cls_s[i]) w_imme[DATA_WIDTH*i +: DATA_WIDTH] = sext32(imm_s(ins));
      else if (w_cls_b[i]) w_imme[DATA_WIDTH*i +: DATA_WIDTH] = sext32(imm_b(ins));
      else if (w_cls_u[i]) w_imme[DATA_WIDTH*i +: DATA_WIDTH] = sext32(imm_u(ins));
      else if (w_cls_j[i]) w_imme[DATA_WIDTH*i +: DATA_WIDTH] = sext32(imm_j(ins));
      else                 w_imme[DATA_WIDTH*i +: DATA_WIDTH] = '0;
    end
  end

  assign in_ready = ~flush & (~r_valid | out_ready);
  assign w_xfer   = in_valid & in_ready;

  // Output register stage: flush wins, then a new transfer, then a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_lane_v  <= '0;
      r_illegal <= '0;
      r_prs1_v  <= '0;
      r_prs2_v  <= '0;
      r_prd_v   <= '0;
      r_func7   <= '0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_func3   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imme    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_valid   <= 1'b1;
      r_lane_v  <= w_lane_v;
      r_illegal <= w_illegal;
      r_prs1_v  <= w_prs1_v;
      r_prs2_v  <= w_prs2_v;
      r_prd_v   <= w_prd_v;
      r_func7   <= w_func7;
      r_pc      <= w_pc;
      r_opcode  <= w_opcode;
      r_func3   <= w_func3;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_imme    <= w_imme;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_lane_v  = r_lane_v;
  assign out_illegal = r_illegal;
  assign out_prs1_v  = r_prs1_v;
  assign out_prs2_v  = r_prs2_v;
  assign out_prd_v   = r_prd_v;
  assign out_func7   = r_func7;
  assign out_pc      = r_pc;
  assign out_opcode  = r_opcode;
  assign out_func3   = r_func3;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_rd      = r_rd;
  assign out_imme    = r_imme;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a transaction model.
module tb_decode_stage;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [32*N-1:0] in_instr = '0;
  logic [N-1:0]    in_lane_v = '0;
  logic [PW-1:0]   in_pc = '0;
  logic [N-1:0]    out_lane_v, out_func7, out_prs1_v, out_prs2_v, out_prd_v, out_illegal;
  logic [PW*N-1:0] out_pc;
  logic [7*N-1:0]  out_opcode;
  logic [3*N-1:0]  out_func3;
  logic [5*N-1:0]  out_rs1, out_rs2, out_rd;
  logic [DW*N-1:0] out_imme;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [N-1:0]    lane_v, illegal, prs1_v, prs2_v, prd_v, func7;
    logic [PW*N-1:0] pc;
    logic [7*N-1:0]  opcode;
    logic [3*N-1:0]  func3;
    logic [5*N-1:0]  rs1, rs2, rd;
    logic [DW*N-1:0] imme;
  } exp_t;

  decode_stage #(.DATA_WIDTH(DW), .DECODE_NUM(N), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lane_v(in_lane_v), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_v(out_lane_v), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imme(out_imme),
    .out_prs1_v(out_prs1_v), .out_prs2_v(out_prs2_v), .out_prd_v(out_prd_v),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Reference decode: immediates from arithmetic shifts of the signed word.
  function automatic exp_t model(input logic [32*N-1:0] instr, input logic [N-1:0] lv,
                                 input logic [PW-1:0] pc);
    exp_t e;
    int k;
    logic [31:0] w;
    logic [6:0] op;
    int si;
    longint sl, imm;
    bit rr, ii, uu, jj, bb, ss, ok;
    e = '0;
    k = N;
    for (int i = 0; i < N; i++) begin
      w  = instr[32*i +: 32];
      op = w[6:0];
      if (lv[i] && k == N &&
          !((op inside {7'h33, 7'h3B, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h23})
            && w[1:0] == 2'b11))
        k = i;
    end
    for (int i = 0; i < N; i++) begin
      w  = instr[32*i +: 32];
      op = w[6:0];
      si = w;
      sl = si;
      rr = op inside {7'h33, 7'h3B};
      ii = op inside {7'h67, 7'h03, 7'h13, 7'h1B};
      uu = op inside {7'h37, 7'h17};
      jj = (op == 7'h6F);
      bb = (op == 7'h63);
      ss = (op == 7'h23);
      e.lane_v[i]  = lv[i] && (i <= k);
      e.illegal[i] = (i == k);
      e.pc[PW*i +: PW] = pc + PW'(4 * i);
      e.opcode[7*i +: 7] = op;
      e.func3[3*i +: 3]  = w[14:12];
      e.func7[i]         = w[30];
      e.rs1[5*i +: 5]    = w[19:15];
      e.rs2[5*i +: 5]    = w[24:20];
      e.rd[5*i +: 5]     = w[11:7];
      if (i == k)  imm = 0;
      else if (ii) imm = sl >>> 20;
      else if (ss) imm = ((sl >>> 25) <<< 5) | longint'(w[11:7]);
      else if (bb) imm = ((sl >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                         (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      else if (uu) imm = (sl >>> 12) <<< 12;
      else if (jj) imm = ((sl >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                         (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      else         imm = 0;
      e.imme[DW*i +: DW] = imm;
      ok = e.lane_v[i] && !e.illegal[i];
      e.prs1_v[i] = ok && (rr || ii || ss || bb) && (w[19:15] != 0);
      e.prs2_v[i] = ok && (rr || ss || bb) && (w[24:20] != 0);
      e.prd_v[i]  = ok && (rr || ii || uu || jj) && (w[11:7] != 0);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 11);
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h3B;  2: w[6:0] = 7'h67;  3: w[6:0] = 7'h03;
      4: w[6:0] = 7'h13;  5: w[6:0] = 7'h1B;  6: w[6:0] = 7'h37;  7: w[6:0] = 7'h17;
      8: w[6:0] = 7'h6F;  9: w[6:0] = 7'h63;  default: w[6:0] = 7'h23;
    endcase
    if (r == 10) w[1:0] = 2'($urandom_range(0, 2));
    else if (r == 11) w[6:2] = 5'b00010;
    if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
    if ($urandom_range(0, 3) == 0) w[24:20] = 5'd0;
    if ($urandom_range(0, 3) == 0) w[11:7]  = 5'd0;
    return w;
  endfunction

  task automatic drain();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_lane_v = 4'b1111; in_instr = {4{32'h00500093}}; in_pc = 64'h40;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_vec++;
    if ({out_lane_v, out_illegal, out_prs1_v, out_prs2_v, out_prd_v} !== '0) begin
      n_err++; $display("FAIL reset_flags got %h want 0",
                        {out_lane_v, out_illegal, out_prs1_v, out_prs2_v, out_prd_v});
    end
    n_vec++;
    if ({out_pc, out_imme, out_rd} !== '0) begin
      n_err++; $display("FAIL reset_fields got nonzero pc=%h imme=%h want 0", out_pc, out_imme);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    flush = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_flush_in_ready got %b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_addi();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_lane_v = 4'b0001;
    in_instr = '0; in_instr[31:0] = 32'h00500093; in_pc = 64'h0;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_lane_v !== 4'b0001) begin
      n_err++; $display("FAIL addi_valid got v=%b lanes=%b want 1/0001", out_valid, out_lane_v);
    end
    n_vec++;
    if (out_imme[63:0] !== 64'd5 || out_rd[4:0] !== 5'd1) begin
      n_err++; $display("FAIL addi_fields got imm=%h rd=%0d want 5/1", out_imme[63:0], out_rd[4:0]);
    end
    n_vec++;
    if ({out_prd_v[0], out_prs1_v[0], out_prs2_v[0]} !== 3'b100) begin
      n_err++; $display("FAIL addi_flags got %b want 100", {out_prd_v[0], out_prs1_v[0], out_prs2_v[0]});
    end
  endtask

  task automatic test_lui_sw();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_lane_v = 4'b0011;
    in_instr = '0; in_instr[31:0] = 32'h80000137; in_instr[63:32] = 32'hFE312E23; in_pc = 64'h1000;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_imme[63:0] !== 64'hFFFFFFFF80000000 || out_prd_v[0] !== 1'b1) begin
      n_err++; $display("FAIL lui_lane0 got imm=%h prd=%b want ffffffff80000000/1",
                        out_imme[63:0], out_prd_v[0]);
    end
    n_vec++;
    if (out_imme[127:64] !== 64'hFFFFFFFFFFFFFFFC) begin
      n_err++; $display("FAIL sw_imm got %h want fffffffffffffffc", out_imme[127:64]);
    end
    n_vec++;
    if ({out_prs1_v[1], out_prs2_v[1], out_prd_v[1]} !== 3'b110) begin
      n_err++; $display("FAIL sw_flags got %b want 110", {out_prs1_v[1], out_prs2_v[1], out_prd_v[1]});
    end
    n_vec++;
    if (out_pc[127:64] !== 64'h1004) begin
      n_err++; $display("FAIL sw_pc got %h want 1004", out_pc[127:64]);
    end
  endtask

  task automatic test_illegal_trunc();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_lane_v = 4'b1111; in_pc = 64'h2000;
    in_instr = {32'h00500093, 32'h00500093, 32'h0000000B, 32'h00500093};
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_lane_v !== 4'b0011 || out_illegal !== 4'b0010) begin
      n_err++; $display("FAIL trunc_lanes got lanes=%b ill=%b want 0011/0010", out_lane_v, out_illegal);
    end
    n_vec++;
    if ({out_prs1_v[1], out_prs2_v[1], out_prd_v[1]} !== 3'b000 || out_prd_v !== 4'b0001) begin
      n_err++; $display("FAIL trunc_flags got prd=%b lane1=%b want 0001/000", out_prd_v,
                        {out_prs1_v[1], out_prs2_v[1], out_prd_v[1]});
    end
    n_vec++;
    if (out_imme[127:64] !== 64'd0) begin
      n_err++; $display("FAIL trunc_imm got %h want 0", out_imme[127:64]);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_lane_v = 4'b0001;
    in_instr = '0; in_instr[31:0] = 32'h00500093; in_pc = 64'h100;
    @(negedge clk);
    out_ready = 1'b0; in_pc = 64'h200;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc[63:0] !== 64'h100) begin
        n_err++; $display("FAIL stall_hold c=%0d got rdy=%b v=%b pc=%h want 0/1/100",
                          c, in_ready, out_valid, out_pc[63:0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_pc[63:0] !== 64'h100) begin
      n_err++; $display("FAIL stall_release got rdy=%b pc=%h want 1/100", in_ready, out_pc[63:0]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_pc[63:0] !== 64'h200) begin
      n_err++; $display("FAIL stall_next got v=%b pc=%h want 1/200", out_valid, out_pc[63:0]);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_dup got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_lane_v = 4'b0001;
    in_instr = '0; in_instr[31:0] = 32'h00500093; in_pc = 64'h300;
    @(negedge clk);
    flush = 1'b1; in_pc = 64'h400;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_ready got v=%b rdy=%b want 1/0", out_valid, in_ready);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_kill got v=%b want 0", out_valid);
    end
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_nocapture got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; in_lane_v = 4'b0011; in_pc = 64'h500;
    in_instr = '0; in_instr[31:0] = 32'h80000137; in_instr[63:32] = 32'hFE312E23;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_lane_v !== '0 || out_pc !== '0 || out_imme !== '0 ||
        {out_prs1_v, out_prs2_v, out_prd_v, out_illegal} !== '0) begin
      n_err++; $display("FAIL async_rst got v=%b lanes=%b pc0=%h want all 0",
                        out_valid, out_lane_v, out_pc[63:0]);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL async_rst_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_lane_v = 4'b0001; in_pc = 64'h600;
    in_instr = '0; in_instr[31:0] = 32'h00500093;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_pc[63:0] !== 64'h600 || out_imme[63:0] !== 64'd5) begin
      n_err++; $display("FAIL async_rst_after got v=%b pc=%h imm=%h want 1/600/5",
                        out_valid, out_pc[63:0], out_imme[63:0]);
    end
  endtask

  task automatic test_random();
    exp_t cur;
    bit exp_v;
    bit exp_rdy;
    cur = '0;
    exp_v = 1'b0;
    drain();
    for (int c = 0; c < 600; c++) begin
      n_vec++;
      if (out_valid !== exp_v) begin
        n_err++; $display("FAIL rnd_valid cyc=%0d got %b want %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if ({out_lane_v, out_illegal} !== {cur.lane_v, cur.illegal}) begin
          n_err++; $display("FAIL rnd_lanes cyc=%0d got %b/%b want %b/%b", c,
                            out_lane_v, out_illegal, cur.lane_v, cur.illegal);
        end
        n_vec++;
        if ({out_prs1_v, out_prs2_v, out_prd_v} !== {cur.prs1_v, cur.prs2_v, cur.prd_v}) begin
          n_err++; $display("FAIL rnd_flags cyc=%0d got %b want %b", c,
                            {out_prs1_v, out_prs2_v, out_prd_v}, {cur.prs1_v, cur.prs2_v, cur.prd_v});
        end
        for (int i = 0; i < N; i++) begin
          if (cur.lane_v[i]) begin
            n_vec++;
            if ({out_pc[PW*i +: PW], out_imme[DW*i +: DW]} !== {cur.pc[PW*i +: PW], cur.imme[DW*i +: DW]}) begin
              n_err++; $display("FAIL rnd_pc_imm cyc=%0d lane=%0d got %h/%h want %h/%h", c, i,
                                out_pc[PW*i +: PW], out_imme[DW*i +: DW],
                                cur.pc[PW*i +: PW], cur.imme[DW*i +: DW]);
            end
            n_vec++;
            if ({out_opcode[7*i +: 7], out_func3[3*i +: 3], out_func7[i], out_rs1[5*i +: 5],
                 out_rs2[5*i +: 5], out_rd[5*i +: 5]} !==
                {cur.opcode[7*i +: 7], cur.func3[3*i +: 3], cur.func7[i], cur.rs1[5*i +: 5],
                 cur.rs2[5*i +: 5], cur.rd[5*i +: 5]}) begin
              n_err++; $display("FAIL rnd_fields cyc=%0d lane=%0d got op=%h rd=%0d want op=%h rd=%0d",
                                c, i, out_opcode[7*i +: 7], out_rd[5*i +: 5],
                                cur.opcode[7*i +: 7], cur.rd[5*i +: 5]);
            end
          end
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_lane_v = 4'($urandom);
      for (int i = 0; i < N; i++) in_instr[32*i +: 32] = rand_instr();
      in_pc = ($urandom_range(0, 7) == 0) ? 64'hFFFFFFFFFFFFFFF8 : {$urandom, $urandom};
      #1;
      exp_rdy = !flush && (!exp_v || out_ready);
      n_vec++;
      if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL rnd_in_ready cyc=%0d got %b want %b", c, in_ready, exp_rdy);
      end
      if (flush) exp_v = 1'b0;
      else if (in_valid && exp_rdy) begin
        cur   = model(in_instr, in_lane_v, in_pc);
        exp_v = 1'b1;
      end else if (out_ready) exp_v = 1'b0;
      @(negedge clk);
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lui_sw();
    test_illegal_trunc();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
